punc_mem_resp: RTL and testbench

PUNC_MEM_RESP -- requirements
Module: punc_mem_resp

---
 rtl/punc_mem_resp.sv | 136 +++++++++++++
 tb/tb_punc_mem_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/punc_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : punc_mem_resp
// Description : Single-port 16-bit word memory behind a valid/ready request
//               and response handshake. Each request waits WAIT cycles
//               before its response is presented. The response is held
//               until the processor consumes it.
//               Optional macro PUNC_MEM_ADDR_CHECK_EN enables address range
//               checking. An out-of-range access sets rsp_err, suppresses
//               any write and returns zero read data. Without the macro,
//               addresses wrap modulo DEPTH.
// Revision    : 1.0  initial release
// ============================================================================
module punc_mem_resp #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_idx;
    logic            r_oor;
    logic            r_rsp_valid;
    logic [15:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic [15:0]     r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic            w_accept;
    logic            w_oor;

    assign w_idx    = req_addr[AW-1:0];
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef PUNC_MEM_ADDR_CHECK_EN
    // Any address bit above the index range marks the access as out of range
    assign w_oor = |(req_addr >> AW);
`else
    // High address bits are dropped so accesses wrap modulo DEPTH
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |(req_addr >> AW);
    assign w_oor            = 1'b0;
`endif

    // Ready is a pure state decode so it has no path from any input
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Array write on the accept edge; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && w_accept && req_we && !w_oor) begin
            r_mem[w_idx] <= req_wdata;
        end
    end

    // Request/wait/response sequencing with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_oor       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we  <= req_we;
                        r_idx <= w_idx;
                        r_oor <= w_oor;
                        if (WAIT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= C_CNT_LOAD;
                        end else begin
                            // Zero wait states: the response is captured
                            // straight from the request inputs
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= (req_we || w_oor) ? 16'h0000 : r_mem[w_idx];
                            r_rsp_err   <= w_oor;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_we || r_oor) ? 16'h0000 : r_mem[r_idx];
                        r_rsp_err   <= r_oor;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_punc_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_punc_mem_resp
// Description : Directed self-checking bench for punc_mem_resp. Three
//               instances are used: WAIT=2, WAIT=0 and WAIT=3, all with
//               DEPTH=256. Expectations follow PUNC_MEM_ADDR_CHECK_EN when
//               it is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_punc_mem_resp;

`ifdef PUNC_MEM_ADDR_CHECK_EN
    localparam bit C_CHK = 1'b1;
`else
    localparam bit C_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [15:0] req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    punc_mem_resp #(.DEPTH(256), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    punc_mem_resp #(.DEPTH(256), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    punc_mem_resp #(.DEPTH(256), .WAIT(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    // Single comparison point: counts and reports mismatches
    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request from IDLE; checks latency and response; optionally consumes it
    task automatic do_req(input int d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int exp_lat,
                          input logic [15:0] exp_rdata, input bit exp_err,
                          input bit consume, input string tag);
        int lat;
        @(negedge clk);
        chk_val({tag, ".ready_in"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_val({tag, ".lat"},   32'(lat),          32'(exp_lat));
        chk_val({tag, ".rdata"}, 32'(rsp_rdata[d]), 32'(exp_rdata));
        chk_val({tag, ".err"},   32'(rsp_err[d]),   32'(exp_err));
        chk_val({tag, ".ready_busy"}, 32'(req_ready[d]), 32'd0);
        if (consume) begin
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready[d] = 1'b0;
            chk_val({tag, ".idle_ready"}, 32'(req_ready[d]), 32'd1);
            chk_val({tag, ".idle_valid"}, 32'(rsp_valid[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0000;
            req_wdata[i] = 16'h0000;
            rsp_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state on every instance
        for (int i = 0; i < 3; i++) begin
            chk_val($sformatf("rst%0d.ready", i), 32'(req_ready[i]), 32'd1);
            chk_val($sformatf("rst%0d.valid", i), 32'(rsp_valid[i]), 32'd0);
            chk_val($sformatf("rst%0d.rdata", i), 32'(rsp_rdata[i]), 32'd0);
            chk_val($sformatf("rst%0d.err", i),   32'(rsp_err[i]),   32'd0);
        end

        // WAIT=2: write then read back
        do_req(0, 1'b1, 16'h0005, 16'hBEEF, 3, 16'h0000, 1'b0, 1'b1, "w2_wr5");
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b1, "w2_rd5");

        // WAIT=0: preload then read, response one cycle after accept
        do_req(1, 1'b1, 16'h0003, 16'h1234, 1, 16'h0000, 1'b0, 1'b1, "w0_wr3");
        do_req(1, 1'b0, 16'h0003, 16'h0000, 1, 16'h1234, 1'b0, 1'b1, "w0_rd3");

        // Backpressure: response held 5 cycles, write pulses meanwhile ignored
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, "bp_rd5");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_val($sformatf("bp.valid%0d", i), 32'(rsp_valid[0]), 32'd1);
            chk_val($sformatf("bp.rdata%0d", i), 32'(rsp_rdata[0]), 32'hBEEF);
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 16'h0005;
            req_wdata[0] = 16'h5555;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        chk_val("bp.release_ready", 32'(req_ready[0]), 32'd1);
        chk_val("bp.release_valid", 32'(rsp_valid[0]), 32'd0);
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b1, "bp_rd5_after");

        // WAIT=3: reset at the second wait cycle of a read
        do_req(2, 1'b1, 16'h0009, 16'hC0DE, 4, 16'h0000, 1'b0, 1'b1, "w3_wr9");
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 16'h0009;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_val("w3_rstwait.ready", 32'(req_ready[2]), 32'd1);
        chk_val("w3_rstwait.valid", 32'(rsp_valid[2]), 32'd0);
        rose = 1'b0;
        repeat (8) begin
            @(negedge clk);
            rose = rose | rsp_valid[2];
        end
        chk_val("w3_rstwait.never_rose", 32'(rose), 32'd0);
        do_req(2, 1'b0, 16'h0009, 16'h0000, 4, 16'hC0DE, 1'b0, 1'b1, "w3_rd9");

        // Write presented together with reset is discarded
        @(negedge clk);
        rst          = 1'b1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'h0005;
        req_wdata[0] = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        req_valid[0] = 1'b0;
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b1, "rstwr_rd5");

        // Reset while a response is held clears the response registers
        do_req(1, 1'b0, 16'h0003, 16'h0000, 1, 16'h1234, 1'b0, 1'b0, "w0_hold3");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_val("rstresp.valid", 32'(rsp_valid[1]), 32'd0);
        chk_val("rstresp.rdata", 32'(rsp_rdata[1]), 32'd0);
        chk_val("rstresp.ready", 32'(req_ready[1]), 32'd1);

        // Address beyond DEPTH: fault with check enabled, wrap otherwise
        do_req(0, 1'b1, 16'h0105, 16'hAAAA, 3, 16'h0000, C_CHK, 1'b1, "oor_wr");
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, C_CHK ? 16'hBEEF : 16'hAAAA,
               1'b0, 1'b1, "oor_rd5");
        do_req(0, 1'b0, 16'h0105, 16'h0000, 3, C_CHK ? 16'h0000 : 16'hAAAA,
               C_CHK, 1'b1, "oor_rd105");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
